imem_loader: RTL and testbench

- Write-side counterpart of the instruction memory read port: a boot loader that fills a writable instruction memory at run time.
- Accepts a byte stream over a valid/ready handshake and packs bytes little-endian into DATA_W-bit words.
- Issues one word write per packed word to the instruction memory write port, at word-aligned byte addresses.
- Holds the pipeline stalled while loading and reports completion plus a running checksum.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_byte_packer.sv | 48 ++++
 rtl/imem_loader.sv | 115 +++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_pkg;

  // Bytes per instruction word (DATA_W is fixed at 32).
  localparam int INSN_BYTES = 4;

  // Default byte-address width of the instruction memory.
  localparam int INS_ADDRESS_DEF = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  // Word depth of an instruction memory with the given byte-address width.
  function automatic int imem_depth(input int ins_address);
    return 1 << (ins_address - 2);
  endfunction

  localparam int IMEM_DEPTH_DEF = imem_depth(INS_ADDRESS_DEF);

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs an accepted byte stream little-endian into DATA_W-bit words.
// o_word_valid fires combinationally on the byte that completes a word,
// with o_word already carrying that final byte in its MSB lane.
module byte_packer
  import imem_pkg::*;
#(
  parameter int DATA_W = 32
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [7:0]        i_byte,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_valid
);

  localparam int CW = $clog2(INSN_BYTES);
  localparam logic [CW-1:0] LAST = CW'(INSN_BYTES - 1);

  logic [CW-1:0]     r_cnt;
  logic [DATA_W-1:0] r_word;
  logic [DATA_W-1:0] w_merged;

  // Merge the incoming byte into its lane of the partial word.
  always_comb begin
    w_merged = r_word;
    w_merged[int'(r_cnt) * 8 +: 8] = i_byte;
  end

  assign o_word       = w_merged;
  assign o_word_valid = i_accept && (r_cnt == LAST);

  // Byte counter and partial word; advance only on accepted bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_accept) begin
      r_word <= w_merged;
      r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills the instruction memory from a byte stream, one
// word write per 4 bytes, stalling the CPU for the duration of the load.
module imem_loader
  import imem_pkg::*;
#(
  parameter int INS_ADDRESS = INS_ADDRESS_DEF,
  parameter int DATA_W      = 32
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INS_ADDRESS-2:0] len_words,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [INS_ADDRESS-1:0] wr_addr,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   cpu_stall,
  output logic                   done,
  output logic [DATA_W-1:0]      checksum
);

  // Length/index counters are one bit wider than the word address so a
  // full-depth load (len == depth) is representable.
  localparam int LW = INS_ADDRESS - 1;
  localparam int IW = INS_ADDRESS - 2;
  localparam logic [LW-1:0] DEPTH_L = LW'(imem_depth(INS_ADDRESS));

  loader_state_t r_state, w_next;

  logic [LW-1:0]          r_len;
  logic [LW-1:0]          r_word_idx;
  logic [LW-1:0]          w_idx_inc;
  logic [LW-1:0]          w_len_clamp;
  logic                   w_start_acc;
  logic                   w_accept;
  logic                   w_word_valid;
  logic [DATA_W-1:0]      w_word;
  logic                   r_wr_en;
  logic [INS_ADDRESS-1:0] r_wr_addr;
  logic [DATA_W-1:0]      r_wr_data;
  logic [DATA_W-1:0]      r_checksum;

  assign w_start_acc = (r_state == IDLE) && start;
  assign w_accept    = (r_state == LOAD) && in_valid;
  assign w_idx_inc   = r_word_idx + LW'(1);
  // Clamp keeps word_idx inside the memory, so the address never wraps.
  assign w_len_clamp = (len_words > DEPTH_L) ? DEPTH_L : len_words;

  byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_start_acc),
    .i_accept     (w_accept),
    .i_byte       (in_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = (w_len_clamp == '0) ? DONE : LOAD;
      LOAD:  if (w_word_valid) w_next = WRITE;
      WRITE: w_next = (w_idx_inc == r_len) ? DONE : LOAD;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Load bookkeeping and registered write port. The write strobe is set on
  // the cycle the last byte is accepted, so it is high exactly in WRITE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len      <= '0;
      r_word_idx <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_checksum <= '0;
    end else begin
      r_wr_en <= w_word_valid;
      if (w_start_acc) begin
        r_len      <= w_len_clamp;
        r_word_idx <= '0;
        r_checksum <= '0;
      end
      if (w_word_valid) begin
        r_wr_addr <= {r_word_idx[IW-1:0], 2'b00};
        r_wr_data <= w_word;
      end
      if (r_state == WRITE) begin
        r_word_idx <= w_idx_inc;
        r_checksum <= r_checksum + r_wr_data;
      end
    end
  end

  assign in_ready  = (r_state == LOAD);
  assign cpu_stall = (r_state == LOAD) || (r_state == WRITE);
  assign done      = (r_state == DONE);
  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign checksum  = r_checksum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader.
module tb_imem_loader;

  localparam int INS_ADDRESS = 9;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   start = 1'b0;
  logic [INS_ADDRESS-2:0] len_words = '0;
  logic                   in_valid = 1'b0;
  logic [7:0]             in_data = '0;
  logic                   in_ready;
  logic                   wr_en;
  logic [INS_ADDRESS-1:0] wr_addr;
  logic [31:0]            wr_data;
  logic                   cpu_stall;
  logic                   done;
  logic [31:0]            checksum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;

  // Monitor records (appended only by the monitor).
  logic [INS_ADDRESS-1:0] mq_addr[$];
  logic [31:0]            mq_data[$];
  int                     mq_cyc[$];
  int                     dq_cyc[$];
  int                     stall_total = 0;
  int                     ready_viol = 0;
  int                     stall_at_done = 0;

  imem_loader #(.INS_ADDRESS(INS_ADDRESS), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .len_words(len_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_stall(cpu_stall), .done(done), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      mq_addr.push_back(wr_addr);
      mq_data.push_back(wr_data);
      mq_cyc.push_back(cyc);
      if (in_ready) ready_viol <= ready_viol + 1;
    end
    if (done) begin
      dq_cyc.push_back(cyc);
      if (cpu_stall) stall_at_done <= stall_at_done + 1;
    end
    if (cpu_stall) stall_total <= stall_total + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [INS_ADDRESS-2:0] n);
    start = 1'b1;
    len_words = n;
    step();
    start = 1'b0;
    start_cyc = cyc;
  endtask

  // Present one byte and hold it until accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      step();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL byte_accept_timeout: byte %02h not accepted, in_ready=%0b required 1", b, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    checks += 7;
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready: got %0b want 0", in_ready); end
    if (wr_en !== 1'b0)     begin errors++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
    if (wr_addr !== '0)     begin errors++; $display("FAIL reset_wr_addr: got %h want 0", wr_addr); end
    if (wr_data !== '0)     begin errors++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_cpu_stall: got %0b want 0", cpu_stall); end
    if (done !== 1'b0)      begin errors++; $display("FAIL reset_done: got %0b want 0", done); end
    if (checksum !== '0)    begin errors++; $display("FAIL reset_checksum: got %h want 0", checksum); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_two_words();
    logic [7:0] bytes_v[8];
    int wb, db, sb;
    bytes_v = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    wb = mq_addr.size(); db = dq_cyc.size(); sb = stall_total;
    do_start(8'd2);
    checks++;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL two_stall_after_start: got %0b want 1", cpu_stall); end
    foreach (bytes_v[i]) send_byte(bytes_v[i]);
    in_valid = 1'b0;
    step(); step(); step();
    checks += 3;
    if (mq_addr.size() - wb != 2) begin
      errors++; $display("FAIL two_write_count: got %0d want 2", mq_addr.size() - wb);
    end else begin
      if (mq_addr[wb] !== 9'h000 || mq_data[wb] !== 32'h00100093) begin
        errors++; $display("FAIL two_write0: got addr %h data %h want 000 00100093", mq_addr[wb], mq_data[wb]);
      end
      if (mq_addr[wb+1] !== 9'h004 || mq_data[wb+1] !== 32'h00200113) begin
        errors++; $display("FAIL two_write1: got addr %h data %h want 004 00200113", mq_addr[wb+1], mq_data[wb+1]);
      end
      checks += 2;
      if (mq_cyc[wb] != start_cyc + 4 || mq_cyc[wb+1] != start_cyc + 9) begin
        errors++; $display("FAIL two_write_timing: got %0d,%0d want %0d,%0d", mq_cyc[wb] - start_cyc, mq_cyc[wb+1] - start_cyc, 4, 9);
      end
      if (dq_cyc.size() - db != 1 || dq_cyc[dq_cyc.size()-1] != mq_cyc[wb+1] + 1) begin
        errors++; $display("FAIL two_done_timing: got %0d pulses want 1 one cycle after write", dq_cyc.size() - db);
      end
    end
    if (checksum !== 32'h003001A6) begin errors++; $display("FAIL two_checksum: got %h want 003001a6", checksum); end
    if (stall_total - sb != 10) begin errors++; $display("FAIL two_stall_cycles: got %0d want 10", stall_total - sb); end
  endtask

  task automatic test_len_zero();
    int wb, db, dc;
    wb = mq_addr.size(); db = dq_cyc.size();
    do_start(8'd0);
    step(); step(); step();
    checks += 3;
    if (mq_addr.size() != wb) begin errors++; $display("FAIL zero_no_write: got %0d writes want 0", mq_addr.size() - wb); end
    if (dq_cyc.size() - db != 1) begin
      errors++; $display("FAIL zero_done_pulse: got %0d pulses want 1", dq_cyc.size() - db);
    end else begin
      dc = dq_cyc[db] - start_cyc;
      if (dc < 0 || dc > 2) begin errors++; $display("FAIL zero_done_pulse: got delay %0d want 0..2", dc); end
    end
    if (checksum !== 32'h0) begin errors++; $display("FAIL zero_checksum: got %h want 0", checksum); end
  endtask

  task automatic test_backpressure();
    logic [7:0] bytes_v[4];
    int wb, vb, g;
    bytes_v = '{8'h33, 8'h70, 8'h00, 8'h00};
    wb = mq_addr.size(); vb = ready_viol;
    // Garbage presented while idle must be ignored.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom); step();
    end
    in_valid = 1'b0;
    do_start(8'd1);
    foreach (bytes_v[i]) begin
      g = $urandom_range(1, 3);
      for (int j = 0; j < g; j++) begin
        in_valid = 1'b0; in_data = 8'($urandom); step();
      end
      send_byte(bytes_v[i]);
      in_valid = 1'b0;
    end
    in_valid = 1'b1; in_data = 8'hEE;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_in_write: got %0b want 0", in_ready); end
    step(); step(); step();
    in_valid = 1'b0;
    checks += 3;
    if (mq_addr.size() - wb != 1) begin
      errors++; $display("FAIL bp_write_count: got %0d want 1", mq_addr.size() - wb);
    end else if (mq_addr[wb] !== 9'h000 || mq_data[wb] !== 32'h00007033) begin
      errors++; $display("FAIL bp_write: got addr %h data %h want 000 00007033", mq_addr[wb], mq_data[wb]);
    end
    if (checksum !== 32'h00007033) begin errors++; $display("FAIL bp_checksum: got %h want 00007033", checksum); end
    if (ready_viol != vb) begin errors++; $display("FAIL bp_ready_viol: got %0d want 0", ready_viol - vb); end
  endtask

  task automatic test_clamp();
    logic [31:0] sum, w0, wl, exp_w;
    int wb, db, seq_bad;
    logic [7:0] b;
    sum = '0; seq_bad = 0;
    wb = mq_addr.size(); db = dq_cyc.size();
    for (int w = 0; w < 128; w++) begin
      exp_w = '0;
      for (int k = 0; k < 4; k++) begin
        b = 8'(((4 * w + k) * 7 + 3) & 255);
        exp_w[8*k +: 8] = b;
      end
      sum = sum + exp_w;
      if (w == 0) w0 = exp_w;
      if (w == 127) wl = exp_w;
    end
    do_start(8'd200);
    for (int i = 0; i < 512; i++) send_byte(8'((i * 7 + 3) & 255));
    in_valid = 1'b0;
    step(); step(); step();
    checks += 4;
    if (mq_addr.size() - wb != 128) begin
      errors++; $display("FAIL clamp_write_count: got %0d want 128", mq_addr.size() - wb);
    end else begin
      for (int i = 0; i < 128; i++)
        if (mq_addr[wb+i] !== 9'(i * 4)) seq_bad++;
      checks += 2;
      if (seq_bad != 0) begin errors++; $display("FAIL clamp_addr_seq: got %0d bad addrs want 0", seq_bad); end
      if (mq_addr[wb+127] !== 9'h1FC) begin errors++; $display("FAIL clamp_last_addr: got %h want 1fc", mq_addr[wb+127]); end
      if (mq_data[wb] !== w0 || mq_data[wb+127] !== wl) begin
        errors++; $display("FAIL clamp_data: got %h/%h want %h/%h", mq_data[wb], mq_data[wb+127], w0, wl);
      end
    end
    if (checksum !== sum) begin errors++; $display("FAIL clamp_checksum: got %h want %h", checksum, sum); end
    if (dq_cyc.size() - db != 1) begin errors++; $display("FAIL clamp_done: got %0d pulses want 1", dq_cyc.size() - db); end
  endtask

  task automatic test_reset_mid();
    int wb, db;
    wb = mq_addr.size();
    do_start(8'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    in_valid = 1'b0;
    reset = 1'b1;
    #2;
    checks += 2;
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL mid_stall_drop: got %0b want 0", cpu_stall); end
    if (in_ready !== 1'b0)  begin errors++; $display("FAIL mid_ready_drop: got %0b want 0", in_ready); end
    step();
    reset = 1'b0;
    step();
    checks++;
    if (mq_addr.size() != wb) begin errors++; $display("FAIL mid_no_write: got %0d writes want 0", mq_addr.size() - wb); end
    db = dq_cyc.size();
    do_start(8'd1);
    send_byte(8'h13);
    send_byte(8'h05);
    // A start during LOAD must neither restart nor relengthen the load.
    start = 1'b1; len_words = 8'd3;
    send_byte(8'h00);
    start = 1'b0;
    send_byte(8'h00);
    in_valid = 1'b0;
    step(); step(); step(); step(); step(); step();
    checks += 3;
    if (mq_addr.size() - wb != 1) begin
      errors++; $display("FAIL mid_new_write_count: got %0d want 1", mq_addr.size() - wb);
    end else if (mq_addr[wb] !== 9'h000 || mq_data[wb] !== 32'h00000513) begin
      errors++; $display("FAIL mid_new_write: got addr %h data %h want 000 00000513", mq_addr[wb], mq_data[wb]);
    end
    if (dq_cyc.size() - db != 1) begin errors++; $display("FAIL mid_done: got %0d pulses want 1", dq_cyc.size() - db); end
    if (checksum !== 32'h00000513) begin errors++; $display("FAIL mid_checksum: got %h want 00000513", checksum); end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_len_zero();
    test_backpressure();
    test_clamp();
    test_reset_mid();
    checks++;
    if (stall_at_done != 0) begin errors++; $display("FAIL stall_at_done: got %0d want 0", stall_at_done); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
